// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// Op encoding, chunk-width derivation and the per-stage carry/valid record.
package adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Width of the slice each pipeline stage ripples through.
    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/adder_chunk_stage.sv
// One pipeline stage: ripples a CHUNK-bit slice plus carry-in,
// then registers the slice sum, the carry-out and the stage valid.
module adder_chunk_stage
    import adder_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  logic             valid_in,
    output logic [CHUNK-1:0] sum,
    output stage_ctl_t       ctl
);

    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

    // Capture the slice result and its carry; hold everything on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            ctl.valid <= 1'b0;
            ctl.carry <= 1'b0;
        end else if (en) begin
            sum       <= full[CHUNK-1:0];
            ctl.valid <= valid_in;
            ctl.carry <= full[CHUNK];
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract: STAGES slices, carry registered
// between stages, operands skewed in and results deskewed out.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1<=STAGES<=WIDTH");
    end

    logic             en;
    logic [WIDTH-1:0] eff_b;
    logic             eff_cin;
    logic             msb_ab;

    logic [CHUNK-1:0] st_a   [STAGES];
    logic [CHUNK-1:0] st_b   [STAGES];
    logic [CHUNK-1:0] st_sum [STAGES];
    stage_ctl_t       st_ctl [STAGES];

    // One global enable: the whole pipe advances unless the output is stuck.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Subtraction is A + ~B + !borrow.
    assign eff_b   = (in_sub == SUB) ? ~in_b : in_b;
    assign eff_cin = in_cin ^ in_sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic cin_k;
        logic vin_k;

        if (k == 0) begin : g_head
            assign st_a[k] = in_a[0 +: CHUNK];
            assign st_b[k] = eff_b[0 +: CHUNK];
            assign cin_k   = eff_cin;
            assign vin_k   = in_valid;
        end else begin : g_skew
            logic [CHUNK-1:0] sk_a [k];
            logic [CHUNK-1:0] sk_b [k];

            // Delay operand slice k by k cycles so it meets its carry.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        sk_a[j] <= '0;
                        sk_b[j] <= '0;
                    end
                end else if (en) begin
                    sk_a[0] <= in_a[k*CHUNK +: CHUNK];
                    sk_b[0] <= eff_b[k*CHUNK +: CHUNK];
                    for (int j = 1; j < k; j++) begin
                        sk_a[j] <= sk_a[j-1];
                        sk_b[j] <= sk_b[j-1];
                    end
                end
            end

            assign st_a[k] = sk_a[k-1];
            assign st_b[k] = sk_b[k-1];
            assign cin_k   = st_ctl[k-1].carry;
            assign vin_k   = st_ctl[k-1].valid;
        end

        adder_chunk_stage #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .a        (st_a[k]),
            .b        (st_b[k]),
            .cin      (cin_k),
            .valid_in (vin_k),
            .sum      (st_sum[k]),
            .ctl      (st_ctl[k])
        );

        if (k == STAGES - 1) begin : g_tail
            assign out_sum[k*CHUNK +: CHUNK] = st_sum[k];
        end else begin : g_deskew
            localparam int D = STAGES - 1 - k;
            logic [CHUNK-1:0] dk [D];

            // Hold finished low slices until the top slice catches up.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < D; j++) begin
                        dk[j] <= '0;
                    end
                end else if (en) begin
                    dk[0] <= st_sum[k];
                    for (int j = 1; j < D; j++) begin
                        dk[j] <= dk[j-1];
                    end
                end
            end

            assign out_sum[k*CHUNK +: CHUNK] = dk[D-1];
        end
    end

    // Keep a^b of the top bit so the carry into the MSB can be recovered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb_ab <= 1'b0;
        end else if (en) begin
            msb_ab <= st_a[STAGES-1][CHUNK-1] ^ st_b[STAGES-1][CHUNK-1];
        end
    end

    assign out_valid = st_ctl[STAGES-1].valid;
    assign out_cout  = st_ctl[STAGES-1].carry;
    assign out_ovf   = msb_ab ^ out_sum[WIDTH-1] ^ out_cout;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed corner vectors,
// backpressure, mid-stream reset, random traffic and 8-bit configs.
module tb_pipelined_adder;

    localparam int W = 32;
    localparam int S = 4;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
        logic        lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic          in_valid, in_ready, in_cin, in_sub;
    logic [W-1:0]  in_a, in_b;
    logic          out_valid, out_ready, out_cout, out_ovf;
    logic [W-1:0]  out_sum;

    logic       s_valid, s_cin, s_sub;
    logic [7:0] s_a, s_b;
    logic       s1_ready, s1_valid, s1_cout, s1_ovf;
    logic [7:0] s1_sum;
    logic       s8_ready, s8_valid, s8_cout, s8_ovf;
    logic [7:0] s8_sum;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t q[$];
    exp_t k_exp;
    logic k_use = 1'b0;
    logic held  = 1'b0;
    logic [31:0] h_sum;
    logic [1:0]  h_fl;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst),
        .in_valid(s_valid), .in_ready(s1_ready),
        .in_a(s_a), .in_b(s_b), .in_cin(s_cin), .in_sub(s_sub),
        .out_valid(s1_valid), .out_ready(1'b1),
        .out_sum(s1_sum), .out_cout(s1_cout), .out_ovf(s1_ovf)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(8)) dut_s8 (
        .clk(clk), .rst(rst),
        .in_valid(s_valid), .in_ready(s8_ready),
        .in_a(s_a), .in_b(s_b), .in_cin(s_cin), .in_sub(s_sub),
        .out_valid(s8_valid), .out_ready(1'b1),
        .out_sum(s8_sum), .out_cout(s8_cout), .out_ovf(s8_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb);
        exp_t m;
        longint ua, ub, sa, sbv, c, r, s;
        logic signed [31:0] t;
        ua = a; ub = b;
        sa = $signed(a); sbv = $signed(b);
        c = ci;
        if (!sb) begin
            r = ua + ub + c;
            s = sa + sbv + c;
            m.cout = (r > 64'h0000_0000_FFFF_FFFF);
        end else begin
            r = ua - ub - c;
            s = sa - sbv - c;
            m.cout = (r >= 0);
        end
        m.sum = r[31:0];
        t = s[31:0];
        m.ovf = (s != longint'(t));
        m.cyc = 0;
        m.lat = 1'b0;
        return m;
    endfunction

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb, input logic ordy,
                        output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b;
        in_cin = ci; in_sub = sb; out_ready = ordy;
        #1;
        if (held) begin
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, h_sum);
            check("hold_flags", {out_cout, out_ovf}, h_fl);
        end
        check("in_ready", in_ready, !out_valid || out_ready);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = q.pop_front();
                check("sum", out_sum, e.sum);
                check("cout", out_cout, e.cout);
                check("ovf", out_ovf, e.ovf);
                if (e.lat) check("latency", cyc - e.cyc, S);
            end
        end
        acc = v && in_ready;
        if (acc) begin
            e = k_use ? k_exp : model(a, b, ci, sb);
            e.cyc = cyc;
            e.lat = k_use;
            q.push_back(e);
        end
        held = out_valid && !out_ready;
        h_sum = out_sum;
        h_fl = {out_cout, out_ovf};
        cyc++;
    endtask

    task automatic send_k(input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb,
                          input logic [31:0] ks, input logic kc, input logic ko);
        logic acc;
        k_exp.sum = ks; k_exp.cout = kc; k_exp.ovf = ko;
        k_use = 1'b1;
        step(1'b1, a, b, ci, sb, 1'b1, acc);
        k_use = 1'b0;
        check("directed_accept", acc, 1);
    endtask

    task automatic drain(input string tag);
        logic acc;
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        end
        check(tag, q.size(), 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic acc, pend;
        logic [31:0] ra, rb;
        logic rc, rs;
        int sent;
        int lat1, lat8;
        logic [7:0] r1s, r8s;
        logic r1c, r1o, r8c, r8o;

        rst = 1'b1;
        in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; in_sub = 0; out_ready = 1;
        s_valid = 0; s_a = 0; s_b = 0; s_cin = 0; s_sub = 0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_flags", {out_cout, out_ovf}, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        send_k(32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0000_0000, 1, 0);
        send_k(32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1);
        send_k(32'h8000_0000, 32'h1, 0, 1, 32'h7FFF_FFFF, 1, 1);
        send_k(32'h5, 32'h7, 0, 1, 32'hFFFF_FFFE, 0, 0);
        send_k(32'h10, 32'h10, 1, 1, 32'hFFFF_FFFF, 0, 0);
        drain("directed_drain");

        sent = 0; pend = 0;
        ra = 0; rb = 0; rc = 0; rs = 0;
        for (int i = 0; i < 60 && (sent < 8 || q.size() > 0); i++) begin
            if (!pend) begin
                ra = $urandom; rb = $urandom;
                rc = 1'($urandom); rs = 1'($urandom);
            end
            step(sent < 8, ra, rb, rc, rs, !(i >= 5 && i <= 9), acc);
            if (sent < 8) pend = !acc;
            if (acc) sent++;
        end
        check("bp_sent", sent, 8);
        check("bp_drain", q.size(), 0);

        k_exp = model(32'h1234_5678, 32'h1111_1111, 0, 0);
        send_k(32'h1234_5678, 32'h1111_1111, 0, 0, k_exp.sum, k_exp.cout, k_exp.ovf);
        send_k(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 1, 0);
        send_k(32'h0, 32'h0, 1, 1, 32'hFFFF_FFFF, 0, 0);
        step(1'b0, '0, '0, 0, 0, 1'b0, acc);
        step(1'b0, '0, '0, 0, 0, 1'b0, acc);
        check("pre_rst_valid", out_valid, 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        #4 rst = 1'b0;
        q.delete();
        held = 1'b0;
        send_k(32'h0000_00FF, 32'h0000_0001, 0, 0, 32'h0000_0100, 0, 0);
        drain("post_rst_drain");

        pend = 0;
        for (int i = 0; i < 300; i++) begin
            logic v;
            if (!pend) begin
                ra = pick(); rb = pick();
                rc = 1'($urandom); rs = 1'($urandom);
                v = ($urandom_range(0, 3) != 0);
            end else begin
                v = 1'b1;
            end
            step(v, ra, rb, rc, rs, $urandom_range(0, 3) != 0, acc);
            pend = v && !acc;
        end
        drain("rand_drain");

        lat1 = -1; lat8 = -1;
        r1s = 0; r8s = 0; r1c = 0; r1o = 0; r8c = 0; r8o = 0;
        @(negedge clk);
        s_a = 8'hFF; s_b = 8'h01; s_cin = 1; s_sub = 0; s_valid = 1;
        #1;
        check("small_in_ready", {s1_ready, s8_ready}, 2'b11);
        @(negedge clk);
        s_valid = 0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (s1_valid && lat1 < 0) begin
                lat1 = c; r1s = s1_sum; r1c = s1_cout; r1o = s1_ovf;
            end
            if (s8_valid && lat8 < 0) begin
                lat8 = c; r8s = s8_sum; r8c = s8_cout; r8o = s8_ovf;
            end
            @(negedge clk);
        end
        check("s1_latency", lat1, 1);
        check("s1_result", {r1s, r1c, r1o}, {8'h01, 1'b1, 1'b0});
        check("s8_latency", lat8, 8);
        check("s8_result", {r8s, r8c, r8o}, {8'h01, 1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
